// File: rtl/freq_detect_pkg.sv
// rtl/freq_detect_pkg.sv - shared period-window helpers and meter state type
package freq_detect_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMING,
      MEASURING
   } meter_state_e;

   // Period window bounds in clock cycles; integer division, bounds are inclusive.
   function automatic int period_min(input int clk, input int f, input int dev);
      return clk / (f + dev);
   endfunction

   function automatic int period_max(input int clk, input int f, input int dev);
      return clk / (f - dev);
   endfunction

endpackage

// File: rtl/period_meter.sv
// rtl/period_meter.sv - sample synchronizer, rising-edge detect and saturating period counter
module period_meter
   import freq_detect_pkg::*;
#(
   parameter int PERIOD_WIDTH = 24
)(
   input  logic                    i_clk,
   input  logic                    i_resetn,
   input  logic                    i_sample,
   input  logic                    i_enable,
   output logic                    o_rise,
   output logic [PERIOD_WIDTH-1:0] o_period
);

   localparam logic [PERIOD_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [PERIOD_WIDTH-1:0] CNT_ONE = PERIOD_WIDTH'(1);

   logic                    r_s1;
   logic                    r_s2;
   logic                    r_s3;
   logic [PERIOD_WIDTH-1:0] r_count;
   meter_state_e            r_state;
   logic                    w_edge;

   assign w_edge = r_s2 & ~r_s3;

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_s1    <= 1'b0;
         r_s2    <= 1'b0;
         r_s3    <= 1'b0;
         r_count <= '0;
         r_state <= IDLE;
      end else begin
         r_s1 <= i_sample;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         case (r_state)
            IDLE: begin
               r_count <= '0;
               if (i_enable) r_state <= ARMING;
            end
            ARMING: begin
               if (!i_enable) begin
                  r_state <= IDLE;
                  r_count <= '0;
               end else if (w_edge) begin
                  r_state <= MEASURING;
                  r_count <= CNT_ONE;
               end
            end
            MEASURING: begin
               // Dropping enable abandons the period in flight; it never spans the gap.
               if (!i_enable) begin
                  r_state <= IDLE;
                  r_count <= '0;
               end else if (w_edge) begin
                  r_count <= CNT_ONE;
               end else if (r_count != CNT_MAX) begin
                  r_count <= r_count + CNT_ONE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_count <= '0;
            end
         endcase
      end
   end

   assign o_rise   = w_edge && i_enable && (r_state == MEASURING);
   assign o_period = r_count;

endmodule

// File: rtl/pixel_frequency_detector.sv
// rtl/pixel_frequency_detector.sv - per-pixel two-band period classifier with saturating accumulators
module pixel_frequency_detector
   import freq_detect_pkg::*;
#(
   parameter int FREQUENCY0           = 5000,
   parameter int FREQUENCY1           = 10000,
   parameter int FREQUENCY0_DEVIATION = 20,
   parameter int FREQUENCY1_DEVIATION = 20,
   parameter int CLOCK_FREQUENCY      = 100000000,
   parameter int PERIOD_WIDTH         = 24,
   parameter int ACC_WIDTH            = 32
)(
   input  logic                    s00_axi_aclk,
   input  logic                    s00_axi_aresetn,
   input  logic                    sample_data,
   input  logic                    enable,
   input  logic                    clear,
   output logic [31:0]             f0_value,
   output logic [31:0]             f1_value,
   output logic [PERIOD_WIDTH-1:0] period_value,
   output logic                    f0_hit,
   output logic                    f1_hit
);

   localparam int P0_MIN = period_min(CLOCK_FREQUENCY, FREQUENCY0, FREQUENCY0_DEVIATION);
   localparam int P0_MAX = period_max(CLOCK_FREQUENCY, FREQUENCY0, FREQUENCY0_DEVIATION);
   localparam int P1_MIN = period_min(CLOCK_FREQUENCY, FREQUENCY1, FREQUENCY1_DEVIATION);
   localparam int P1_MAX = period_max(CLOCK_FREQUENCY, FREQUENCY1, FREQUENCY1_DEVIATION);

   localparam logic [PERIOD_WIDTH-1:0] W0_LO = PERIOD_WIDTH'(P0_MIN);
   localparam logic [PERIOD_WIDTH-1:0] W0_HI = PERIOD_WIDTH'(P0_MAX);
   localparam logic [PERIOD_WIDTH-1:0] W1_LO = PERIOD_WIDTH'(P1_MIN);
   localparam logic [PERIOD_WIDTH-1:0] W1_HI = PERIOD_WIDTH'(P1_MAX);

   localparam int SUM_W = ((ACC_WIDTH > PERIOD_WIDTH) ? ACC_WIDTH : PERIOD_WIDTH) + 1;
   localparam logic [SUM_W-1:0] ACC_MAX = SUM_W'({ACC_WIDTH{1'b1}});

   logic                    w_rise;
   logic [PERIOD_WIDTH-1:0] w_period;
   logic                    w_sat;
   logic                    w_in0;
   logic                    w_in1;
   logic [SUM_W-1:0]        w_sum0;
   logic [SUM_W-1:0]        w_sum1;
   logic [ACC_WIDTH-1:0]    w_next0;
   logic [ACC_WIDTH-1:0]    w_next1;

   logic [ACC_WIDTH-1:0]    r_f0;
   logic [ACC_WIDTH-1:0]    r_f1;
   logic [PERIOD_WIDTH-1:0] r_period;
   logic                    r_f0_hit;
   logic                    r_f1_hit;

   period_meter #(
      .PERIOD_WIDTH (PERIOD_WIDTH)
   ) u_meter (
      .i_clk    (s00_axi_aclk),
      .i_resetn (s00_axi_aresetn),
      .i_sample (sample_data),
      .i_enable (enable),
      .o_rise   (w_rise),
      .o_period (w_period)
   );

   // A saturated count means the true period is unknown, so it never qualifies.
   assign w_sat = &w_period;
   assign w_in0 = w_rise && !w_sat && (w_period >= W0_LO) && (w_period <= W0_HI);
   assign w_in1 = w_rise && !w_sat && (w_period >= W1_LO) && (w_period <= W1_HI);

   assign w_sum0  = SUM_W'(r_f0) + SUM_W'(w_period);
   assign w_sum1  = SUM_W'(r_f1) + SUM_W'(w_period);
   assign w_next0 = (w_sum0 > ACC_MAX) ? '1 : w_sum0[ACC_WIDTH-1:0];
   assign w_next1 = (w_sum1 > ACC_MAX) ? '1 : w_sum1[ACC_WIDTH-1:0];

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         r_f0     <= '0;
         r_f1     <= '0;
         r_period <= '0;
         r_f0_hit <= 1'b0;
         r_f1_hit <= 1'b0;
      end else begin
         r_f0_hit <= w_in0;
         r_f1_hit <= w_in1;
         if (w_rise && !w_sat) r_period <= w_period;
         if (!clear) begin
            r_f0 <= '0;
            r_f1 <= '0;
         end else begin
            if (w_in0) r_f0 <= w_next0;
            if (w_in1) r_f1 <= w_next1;
         end
      end
   end

   assign f0_value     = 32'(r_f0);
   assign f1_value     = 32'(r_f1);
   assign period_value = r_period;
   assign f0_hit       = r_f0_hit;
   assign f1_hit       = r_f1_hit;

endmodule

// File: tb/tb_pixel_frequency_detector.sv
// tb/tb_pixel_frequency_detector.sv - directed bench with a timestamp-based reference model
module tb_pixel_frequency_detector;
   import freq_detect_pkg::*;

   // Scaled clock so that in-band periods are a few hundred cycles long.
   localparam int CLK_HZ = 100000;
   localparam int F0     = 500;
   localparam int D0     = 20;
   localparam int F1     = 1000;
   localparam int D1     = 20;
   localparam int PW     = 10;
   localparam int AW     = 12;

   localparam int P0MIN  = period_min(CLK_HZ, F0, D0);
   localparam int P0MAX  = period_max(CLK_HZ, F0, D0);
   localparam int P1MIN  = period_min(CLK_HZ, F1, D1);
   localparam int P1MAX  = period_max(CLK_HZ, F1, D1);
   localparam int CMAX   = (1 << PW) - 1;
   localparam int ACCMAX = (1 << AW) - 1;

   logic          clk = 1'b0;
   logic          resetn;
   logic          sample;
   logic          enable;
   logic          clear;
   logic [31:0]   f0_value;
   logic [31:0]   f1_value;
   logic [PW-1:0] period_value;
   logic          f0_hit;
   logic          f1_hit;

   int tests = 0;
   int fails = 0;
   int h0cnt = 0;
   int h1cnt = 0;

   int m_f0 = 0;
   int m_f1 = 0;
   int m_per = 0;
   bit m_h0 = 0;
   bit m_h1 = 0;
   int m_mode = 0;
   int m_last = 0;
   bit m_prev = 0;
   int t = 0;
   int rq[$];

   pixel_frequency_detector #(
      .FREQUENCY0           (F0),
      .FREQUENCY1           (F1),
      .FREQUENCY0_DEVIATION (D0),
      .FREQUENCY1_DEVIATION (D1),
      .CLOCK_FREQUENCY      (CLK_HZ),
      .PERIOD_WIDTH         (PW),
      .ACC_WIDTH            (AW)
   ) dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (resetn),
      .sample_data     (sample),
      .enable          (enable),
      .clear           (clear),
      .f0_value        (f0_value),
      .f1_value        (f1_value),
      .period_value    (period_value),
      .f0_hit          (f0_hit),
      .f1_hit          (f1_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Model: rising edges are timestamped when driven and take effect two edges later;
   // a period is the timestamp difference between consecutive effective edges.
   initial begin
      bit r;
      int p;
      forever begin
         @(posedge clk);
         #1;
         m_h0 = 0;
         m_h1 = 0;
         if (!resetn) begin
            m_f0 = 0; m_f1 = 0; m_per = 0;
            m_mode = 0; m_prev = 0;
            rq.delete();
         end else begin
            r = (rq.size() > 0) && (rq[0] == t - 2);
            if (r) void'(rq.pop_front());
            if (sample && !m_prev) rq.push_back(t);
            m_prev = sample;
            if (!enable) m_mode = 0;
            else if (m_mode == 0) m_mode = 1;
            else if (r) begin
               if (m_mode == 2) begin
                  p = t - m_last;
                  if (p < CMAX) begin
                     m_per = p;
                     if (p >= P0MIN && p <= P0MAX) begin
                        m_h0 = 1;
                        m_f0 = (m_f0 + p > ACCMAX) ? ACCMAX : m_f0 + p;
                     end
                     if (p >= P1MIN && p <= P1MAX) begin
                        m_h1 = 1;
                        m_f1 = (m_f1 + p > ACCMAX) ? ACCMAX : m_f1 + p;
                     end
                  end
               end
               m_mode = 2;
               m_last = t;
            end
            if (!clear) begin
               m_f0 = 0;
               m_f1 = 0;
            end
         end
         t++;
         chk("model_f0", f0_value, m_f0);
         chk("model_f1", f1_value, m_f1);
         chk("model_period", period_value, m_per);
         chk("model_f0_hit", f0_hit, m_h0);
         chk("model_f1_hit", f1_hit, m_h1);
         if (f0_hit === 1'b1) h0cnt++;
         if (f1_hit === 1'b1) h1cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One rising edge, then p cycles until the caller's next edge; optionally pulse
   // clear low on exactly the edge where this rise is processed.
   task automatic pulse_gap(input int p, input bit clr);
      sample = 1'b1;
      for (int i = 0; i < p; i++) begin
         if (i == 10) sample = 1'b0;
         if (clr && i == 2) clear = 1'b0;
         if (clr && i == 3) begin
            clear = 1'b1;
            chk("clear_coincident_f0", f0_value, 0);
            chk("clear_coincident_f1", f1_value, 0);
         end
         @(negedge clk);
      end
   endtask

   task automatic rearm();
      enable = 1'b0;
      tick(3);
      enable = 1'b1;
      tick(3);
   endtask

   task automatic clear_pulse();
      clear = 1'b0;
      tick(1);
      clear = 1'b1;
      tick(1);
   endtask

   initial begin
      int b0;
      int b1;
      int ivl[8];
      resetn = 1'b0;
      sample = 1'b0;
      enable = 1'b0;
      clear  = 1'b1;
      tick(3);
      chk("reset_f0", f0_value, 0);
      chk("reset_f1", f1_value, 0);
      chk("reset_period", period_value, 0);
      chk("reset_hits", {f0_hit, f1_hit}, 0);
      resetn = 1'b1;
      tick(2);

      // Band 0 square wave: 5 edges, 4 periods of 200
      b0 = h0cnt; b1 = h1cnt;
      rearm();
      repeat (5) pulse_gap(200, 1'b0);
      chk("sq200_f0", f0_value, 800);
      chk("sq200_f1", f1_value, 0);
      chk("sq200_period", period_value, 200);
      chk("sq200_f0_hits", h0cnt - b0, 4);
      chk("sq200_f1_hits", h1cnt - b1, 0);

      // Band 1, then an out-of-band rate that must change nothing
      clear_pulse();
      chk("clear_only_f0", f0_value, 0);
      rearm();
      repeat (3) pulse_gap(100, 1'b0);
      chk("sq100_f1", f1_value, 200);
      chk("sq100_f0", f0_value, 0);
      b0 = h0cnt; b1 = h1cnt;
      rearm();
      repeat (3) pulse_gap(150, 1'b0);
      chk("sq150_f1", f1_value, 200);
      chk("sq150_f0", f0_value, 0);
      chk("sq150_period", period_value, 150);
      chk("sq150_hits", (h0cnt - b0) + (h1cnt - b1), 0);

      // Window boundaries: inclusive limits accepted, one past rejected
      clear_pulse();
      rearm();
      b0 = h0cnt; b1 = h1cnt;
      ivl = '{192, 208, 191, 209, 98, 102, 97, 103};
      foreach (ivl[i]) pulse_gap(ivl[i], 1'b0);
      pulse_gap(20, 1'b0);
      chk("bound_f0", f0_value, 400);
      chk("bound_f1", f1_value, 200);
      chk("bound_period", period_value, 103);
      chk("bound_f0_hits", h0cnt - b0, 2);
      chk("bound_f1_hits", h1cnt - b1, 2);

      // Clear coincident with a qualifying rise wins; next period accumulates
      clear_pulse();
      rearm();
      pulse_gap(200, 1'b0);
      pulse_gap(200, 1'b0);
      chk("pre_clear_f0", f0_value, 200);
      pulse_gap(200, 1'b1);
      pulse_gap(20, 1'b0);
      chk("post_clear_f0", f0_value, 200);

      // Enable dropped mid-period: the spanning period is never used
      rearm();
      pulse_gap(200, 1'b0);
      sample = 1'b1;
      tick(10);
      sample = 1'b0;
      tick(10);
      enable = 1'b0;
      tick(150);
      enable = 1'b1;
      tick(30);
      chk("pre_drop_f0", f0_value, 400);
      pulse_gap(200, 1'b0);
      chk("rearm_only_f0", f0_value, 400);
      pulse_gap(20, 1'b0);
      chk("after_rearm_f0", f0_value, 600);

      // Counter saturation: a long-low period is discarded entirely
      pulse_gap(1100, 1'b0);
      pulse_gap(200, 1'b0);
      chk("sat_period_kept", period_value, 20);
      chk("sat_f0_kept", f0_value, 600);
      pulse_gap(20, 1'b0);
      chk("post_sat_f0", f0_value, 800);
      chk("post_sat_period", period_value, 200);

      // Accumulator saturation: 21 * 200 exceeds 2^12-1
      clear_pulse();
      rearm();
      repeat (22) pulse_gap(200, 1'b0);
      chk("acc_sat_f0", f0_value, 4095);
      chk("acc_sat_f1", f1_value, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pixel_frequency_detector.md
# pixel_frequency_detector

Per-pixel frequency detector. It takes the 1-bit thresholded sample stream of one monitored pixel from the pixel sampler. It measures the period between rising edges in s00_axi_aclk cycles and accumulates total "action time" (cycles) for two target frequency bands. Three instances sit between the pixel sampler and the frequency_analyzer_manager register writer, which reads f0_value/f1_value once stop is asserted.

## Interface
Parameters:
- FREQUENCY0, 5000, band 0 centre (Hz)
- FREQUENCY1, 10000, band 1 centre (Hz)
- FREQUENCY0_DEVIATION, 20, band 0 half-width (Hz); must be < FREQUENCY0
- FREQUENCY1_DEVIATION, 20, band 1 half-width (Hz); must be < FREQUENCY1
- CLOCK_FREQUENCY, 100000000, s00_axi_aclk rate (Hz)
- PERIOD_WIDTH, 24, period counter width
- ACC_WIDTH, 32, accumulator width (≤ 32)

Ports:
- s00_axi_aclk  in  1  sole clock
- s00_axi_aresetn  in  1  reset; one clock, reset is synchronous and active-low
- sample_data  in  1  pixel sample; asynchronous to s00_axi_aclk
- enable  in  1  level; measurement runs while high
- clear  in  1  synchronous, active-low; zeroes accumulators
- f0_value  out  32  band 0 accumulated cycles, zero-extended from ACC_WIDTH
- f1_value  out  32  band 1 accumulated cycles
- period_value  out  PERIOD_WIDTH  last measured period
- f0_hit  out  1  one-cycle pulse: last period fell in band 0
- f1_hit  out  1  one-cycle pulse: last period fell in band 1

## Operation
- Period windows are localparams with integer division and inclusive bounds. P0_MIN = CLOCK_FREQUENCY/(FREQUENCY0+FREQUENCY0_DEVIATION). P0_MAX = CLOCK_FREQUENCY/(FREQUENCY0-FREQUENCY0_DEVIATION). Band 1 windows follow the same rule.
- sample_data passes through a 2-FF synchronizer, then a third FF. rise = s2 & ~s3.
- States:
  - IDLE: enable low. Counter is held at 0 and the measurement is disarmed.
  - ARMING: enable high, no rise seen yet.
  - MEASURING: at least one rise seen.
- Transitions:
  - IDLE→ARMING when enable goes high.
  - ARMING→MEASURING on the first rise. The counter loads 1; nothing is accumulated.
  - Any state→IDLE when enable goes low.
- MEASURING behaviour:
  - The counter increments each cycle and saturates at all-ones.
  - On rise, P = counter. The counter reloads 1 and period_value <= P.
  - If P0_MIN ≤ P ≤ P0_MAX, f0_value += P and f0_hit pulses. Band 1 uses the same test with its own window.
  - If the bands overlap, both accumulate.
  - A saturated P is never in band and is discarded.
- Accumulators saturate at 2^ACC_WIDTH−1 and never wrap.
- Accumulators and period_value hold their values through IDLE. Only clear or reset zeroes them. This lets the manager read them after stop.
- Priority: reset > clear > accumulate. If clear and a qualifying rise occur in the same cycle, the accumulators become 0, not P. Clear does not change the state or the counter.

## Timing
- Reset values:
  - f0_value, f1_value, period_value = 0.
  - f0_hit, f1_hit = 0.
  - State IDLE; synchronizer FFs = 0.
- Latency: sample_data high at clock edge k gives s1 at k, s2 at k+1, and rise during cycle k+1..k+2. Outputs and hit pulses update at edge k+2.
- Hit pulses are exactly 1 cycle wide.
- Reset mid-measurement loses everything. The first rise after reset only arms.
- When enable drops, the period in progress is abandoned. When enable rises again, the block re-arms. It never uses a period spanning the disabled interval.

## Structure
- Shared package freq_detect_pkg holds:
  - function period_min(clk, f, dev) and period_max(clk, f, dev), reused by all three instances and by the bench model;
  - the state enum IDLE/ARMING/MEASURING.
- One sub-module, period_meter. It contains the synchronizer, edge detect, saturating counter and state machine, and outputs rise and P.
- The top level holds the window compares and the saturating accumulators.

## Test plan
All scenarios use default parameters; band 0 window is 19920..20080 and band 1 window is 9980..10020.
- Square wave with period 20000 cycles, 5 rising edges, enable high → f0_value=80000, f1_value=0, period_value=20000, four f0_hit pulses.
- Period 10000 cycles, 3 edges → f1_value=20000, f0_value=0. Then period 15000 cycles, 3 edges → no change to either accumulator and no hits.
- Boundary checks:
  - periods 19920 and 20080 → each added;
  - periods 19919 and 20081 → rejected;
  - the same checks at 9980/10020 and 9979/10021 for band 1.
- Set clear low for one cycle coincident with a qualifying rise → both accumulators read 0 on the next cycle. The next qualifying period accumulates normally.
- Drop enable mid-period, then raise it again 50000 cycles later → the first rise only arms, with no accumulation. Values from before the enable drop are retained.
- Saturation: ACC_WIDTH=16, period 20000, 5 edges → f0_value=65535. With the sample input stuck low for 2^24 cycles, the counter saturates and the next rise is discarded.
